uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

UART receive controller that sequences the receiver's serial-in/parallel-out shift register. Synchronises the raw serial line, detects and qualifies the start bit, and times mid-bit sampling with an internal baud counter. Drives the SIPO's shift/enable/data strobes one bit at a time, checks the stop bit, and reports each completed byte through a valid/ready status handshake. Sits between the pad-level `rx_in` and the SIPO datapath in the receive path.

## Interface

Parameters:
- CLKS_PER_BIT, 868, Clk cycles per bit (100 MHz / 115200); must be an even number ≥ 4
- CNT_W, 16, width of the baud counter; must satisfy 2^CNT_W > CLKS_PER_BIT

Ports:
- Clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- rx_in  in  1  raw serial line, idle high, asynchronous to Clk
- sipo_data  out  1  sampled bit presented to the SIPO
- sipo_shift  out  1  one-cycle strobe: SIPO captures `sipo_data`
- sipo_enable  out  1  high from start-bit confirmation until the stop-bit decision
- rx_valid  out  1  byte complete with a good stop bit; held until accepted
- rx_ready  in  1  consumer accepts; valid is cleared when rx_valid && rx_ready
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled low
- rx_overrun  out  1  one-cycle pulse: byte completed while rx_valid was still pending
- rx_parity_err  out  1  one-cycle pulse: parity mismatch (see Configuration)
- rx_busy  out  1  high in every state except IDLE

## Operation

- `rx_in` passes through a 2-flop synchroniser (reset value 1). All logic uses the synchronised value `rx_s`.
- States: IDLE, START, DATA, [PARITY], STOP, BREAK.
- IDLE, when `rx_s` = 0: go to START, with cnt = 0.
- START: count to CLKS_PER_BIT/2 − 1.
  - If `rx_s` = 0 there: the start is confirmed. Go to DATA, with cnt = 0, bit_idx = 0, and assert `sipo_enable`.
  - If `rx_s` = 1 there: false start. Return to IDLE with no strobes.
- DATA: at cnt = CLKS_PER_BIT − 1:
  - sample `rx_s` into `sipo_data` and pulse `sipo_shift` (bits are LSB first, bit_idx 0..7);
  - reset cnt;
  - after bit_idx 7, go to STOP, or to PARITY if that is compiled in.
- STOP: at cnt = CLKS_PER_BIT − 1:
  - If `rx_s` = 1: set `rx_valid`. If `rx_valid` was already set and not accepted in the same cycle, pulse `rx_overrun` and keep `rx_valid` = 1. Go to IDLE.
  - If `rx_s` = 0: pulse `rx_frame_err`, leave `rx_valid` unchanged, and go to BREAK.
- BREAK: wait for `rx_s` = 1, then go to IDLE. This prevents a held-low line from being read as a stream of start bits.
- `sipo_enable` drops on the cycle the stop-bit decision is made.
- Reset: all outputs go to 0, the state goes to IDLE, and cnt and bit_idx go to 0. Reset mid-frame discards the partial byte, produces no `rx_valid`, and produces no error pulse.

## Timing

- Let T0 be the first cycle in START. Data bit k is strobed at T0 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
- The stop decision is made at T0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT (one CLKS_PER_BIT later with parity).
- The line-to-T0 latency is 3 cycles (2 synchroniser stages plus the IDLE detect).
- `rx_valid` rises 1 cycle after the stop decision (registered).
- `rx_ready` is sampled each cycle. When `rx_valid` && `rx_ready` is high, `rx_valid` is 0 on the next cycle.
- If a new byte completes in the same cycle that the old one is accepted, `rx_valid` stays 1 and no overrun is reported.
- A back-to-back frame is accepted: IDLE detects a start in the first cycle after STOP.

## Configuration

- `UART_RX_PARITY_EN`
  - Defined: adds the PARITY state after bit 7, plus a parameter PARITY_ODD (default 0, meaning even parity). The sampled parity bit is compared with the XOR of the 8 data bits. On a mismatch, pulse `rx_parity_err` at the parity sample. The frame still proceeds to STOP, and `rx_valid` is still raised on a good stop.
  - Undefined: there is no PARITY state, and `rx_parity_err` is tied to 0.

## Structure

- Shared package `uart_pkg` holds:
  - the state enum `rx_state_t`;
  - the constants `UART_DATA_BITS` = 8 and `UART_IDLE_LEVEL` = 1.
- Sub-module `uart_rx_sync`: the 2-flop synchroniser with a reset value of 1. It is reused by the transmitter's CTS input.

## Test plan

All scenarios use CLKS_PER_BIT = 16.

- Frame 0xA5 with a good stop and `rx_ready` = 0 → eight `sipo_shift` strobes with `sipo_data` = 1,0,1,0,0,1,0,1 at the specified cycles. `rx_valid` rises and is held; asserting `rx_ready` for one cycle clears it.
- A 4-cycle low glitch on `rx_in` → START aborts, no strobes, back in IDLE, `rx_busy` low.
- Frame 0x3C with the stop bit low, and the line held low for 40 cycles → `rx_frame_err` pulses once, `rx_valid` stays 0, the block stays in BREAK until the line goes high, and no spurious start follows.
- Two back-to-back frames 0x11 then 0x22 with `rx_ready` = 0 → `rx_overrun` pulses at the second stop decision and `rx_valid` stays 1.
- Reset asserted after bit 3 of 0xFF → all outputs go to 0 immediately. After release the line idles, no `rx_valid` appears, and a following 0x55 frame is received correctly.
- With `UART_RX_PARITY_EN`, even parity, frame 0x07 with parity bit 0 → `rx_parity_err` pulses and `rx_valid` is still asserted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding, frame constants and parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // High when the received parity bit disagrees with the running XOR of the data bits.
  function automatic logic parity_mismatch(input logic data_xor, input logic par_bit, input logic odd);
    return ((data_xor ^ par_bit) != odd);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous serial lines; resets to the idle (high) level.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic Clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] sync_r;

  // Shift the raw line through two flops to settle metastability.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      sync_r <= {2{UART_IDLE_LEVEL}};
    end else begin
      sync_r <= {sync_r[0], d};
    end
  end

  assign q = sync_r[1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start qualification, mid-bit sampling and SIPO strobe sequencing.
// Optional parity check is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter logic PARITY_ODD = 1'b0
`endif
) (
  input  logic Clk,
  input  logic reset,
  input  logic rx_in,
  output logic sipo_data,
  output logic sipo_shift,
  output logic sipo_enable,
  output logic rx_valid,
  input  logic rx_ready,
  output logic rx_frame_err,
  output logic rx_overrun,
  output logic rx_parity_err,
  output logic rx_busy
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_IDX  = 3'(UART_DATA_BITS - 1);

  logic             rx_s;
  rx_state_t        state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       bit_idx_r, bit_idx_s;
  logic             par_r, par_s;
  logic             data_r, data_s;
  logic             shift_r, shift_s;
  logic             enable_r, enable_s;
  logic             valid_r, valid_s;
  logic             ferr_r, ferr_s;
  logic             ovr_r, ovr_s;
  logic             perr_r, perr_s;

  uart_rx_sync u_sync (
    .Clk   (Clk),
    .reset (reset),
    .d     (rx_in),
    .q     (rx_s)
  );

  // Next-state and next-output decode for the receive sequencer.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r + CNT_W'(1'b1);
    bit_idx_s = bit_idx_r;
    par_s     = par_r;
    data_s    = data_r;
    shift_s   = 1'b0;
    enable_s  = enable_r;
    ferr_s    = 1'b0;
    ovr_s     = 1'b0;
    perr_s    = 1'b0;
    if (valid_r && rx_ready) begin
      valid_s = 1'b0;
    end else begin
      valid_s = valid_r;
    end

    case (state_r)
      IDLE: begin
        cnt_s = {CNT_W{1'b0}};
        if (!rx_s) begin
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_s = {CNT_W{1'b0}};
          if (!rx_s) begin
            state_s   = DATA;
            bit_idx_s = 3'd0;
            par_s     = 1'b0;
            enable_s  = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s   = {CNT_W{1'b0}};
          data_s  = rx_s;
          shift_s = 1'b1;
          par_s   = par_r ^ rx_s;
          if (bit_idx_r == LAST_IDX) begin
            bit_idx_s = 3'd0;
`ifdef UART_RX_PARITY_EN
            state_s   = PARITY;
`else
            state_s   = STOP;
`endif
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          state_s = DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s   = {CNT_W{1'b0}};
          perr_s  = parity_mismatch(par_r, rx_s, PARITY_ODD);
          state_s = STOP;
        end else begin
          state_s = PARITY;
        end
      end
`endif
      STOP: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s    = {CNT_W{1'b0}};
          enable_s = 1'b0;
          if (rx_s) begin
            // A byte landing while the previous one is still unclaimed is an overrun.
            ovr_s   = valid_r && !rx_ready;
            valid_s = 1'b1;
            state_s = IDLE;
          end else begin
            ferr_s  = 1'b1;
            state_s = BREAK;
          end
        end else begin
          state_s = STOP;
        end
      end
      BREAK: begin
        cnt_s = {CNT_W{1'b0}};
        if (rx_s) begin
          state_s = IDLE;
        end else begin
          state_s = BREAK;
        end
      end
      default: begin
        state_s   = IDLE;
        cnt_s     = {CNT_W{1'b0}};
        bit_idx_s = 3'd0;
        enable_s  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      bit_idx_r <= 3'd0;
      par_r     <= 1'b0;
      data_r    <= 1'b0;
      shift_r   <= 1'b0;
      enable_r  <= 1'b0;
      valid_r   <= 1'b0;
      ferr_r    <= 1'b0;
      ovr_r     <= 1'b0;
      perr_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_idx_r <= bit_idx_s;
      par_r     <= par_s;
      data_r    <= data_s;
      shift_r   <= shift_s;
      enable_r  <= enable_s;
      valid_r   <= valid_s;
      ferr_r    <= ferr_s;
      ovr_r     <= ovr_s;
      perr_r    <= perr_s;
    end
  end

  assign sipo_data     = data_r;
  assign sipo_shift    = shift_r;
  assign sipo_enable   = enable_r;
  assign rx_valid      = valid_r;
  assign rx_frame_err  = ferr_r;
  assign rx_overrun    = ovr_r;
  assign rx_parity_err = perr_r;
  assign rx_busy       = (state_r != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl at CLKS_PER_BIT = 16.
// Frames carry a parity bit when UART_RX_PARITY_EN is defined.
module tb_uart_rx_ctrl;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME    = CPB * NB;
  localparam int T0       = 3;
  localparam int STOP_DEC = T0 + CPB / 2 + (NB - 1) * CPB;

  logic Clk = 1'b0;
  logic reset, rx_in, rx_ready;
  logic sipo_data, sipo_shift, sipo_enable, rx_valid;
  logic rx_frame_err, rx_overrun, rx_parity_err, rx_busy;

  int n_checks = 0;
  int n_errors = 0;

  logic line_q[$];
  int   shift_cyc[$];
  logic shift_bit[$];
  logic valid_hist[$];
  logic busy_hist[$];
  int   ferr_cnt, ferr_cyc, ovr_cnt, ovr_cyc, perr_cnt, perr_cyc, en_rise, en_drop;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .Clk           (Clk),
    .reset         (reset),
    .rx_in         (rx_in),
    .sipo_data     (sipo_data),
    .sipo_shift    (sipo_shift),
    .sipo_enable   (sipo_enable),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_frame_err  (rx_frame_err),
    .rx_overrun    (rx_overrun),
    .rx_parity_err (rx_parity_err),
    .rx_busy       (rx_busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic push_bits(input logic b, input int n);
    for (int i = 0; i < n; i++) line_q.push_back(b);
  endtask

  task automatic build_frame(input logic [7:0] d, input logic stop_bit);
    push_bits(1'b0, CPB);
    for (int k = 0; k < 8; k++) push_bits(d[k], CPB);
`ifdef UART_RX_PARITY_EN
    push_bits(^d, CPB);
`endif
    push_bits(stop_bit, CPB);
  endtask

  // Plays line_q onto rx_in (idle high afterwards); entry n of the histories is the value after edge n.
  task automatic run_cycles(input int ncyc);
    shift_cyc.delete(); shift_bit.delete(); valid_hist.delete(); busy_hist.delete();
    ferr_cnt = 0; ferr_cyc = -1; ovr_cnt = 0; ovr_cyc = -1;
    perr_cnt = 0; perr_cyc = -1; en_rise = -1; en_drop = -1;
    valid_hist.push_back(rx_valid);
    busy_hist.push_back(rx_busy);
    for (int c = 0; c < ncyc; c++) begin
      rx_in = (c < line_q.size()) ? line_q[c] : 1'b1;
      @(posedge Clk);
      #1;
      if (sipo_shift) begin
        shift_cyc.push_back(c + 1);
        shift_bit.push_back(sipo_data);
      end
      if (rx_frame_err)  begin ferr_cnt++; ferr_cyc = c + 1; end
      if (rx_overrun)    begin ovr_cnt++;  ovr_cyc  = c + 1; end
      if (rx_parity_err) begin perr_cnt++; perr_cyc = c + 1; end
      if (sipo_enable && en_rise < 0) en_rise = c + 1;
      if (!sipo_enable && en_rise >= 0 && en_drop < 0) en_drop = c + 1;
      valid_hist.push_back(rx_valid);
      busy_hist.push_back(rx_busy);
    end
    rx_in = 1'b1;
    line_q.delete();
  endtask

  function automatic logic [7:0] byte_at(input int first);
    logic [7:0] b = 8'h00;
    for (int k = 0; k < 8; k++)
      if (first + k < shift_bit.size()) b[k] = shift_bit[first + k];
    return b;
  endfunction

  function automatic int valid_count();
    int n = 0;
    foreach (valid_hist[i]) if (valid_hist[i]) n++;
    return n;
  endfunction

  function automatic int busy_count();
    int n = 0;
    foreach (busy_hist[i]) if (busy_hist[i]) n++;
    return n;
  endfunction

  function automatic logic [7:0] all_outs();
    return {sipo_data, sipo_shift, sipo_enable, rx_valid, rx_frame_err, rx_overrun, rx_parity_err, rx_busy};
  endfunction

  initial begin
    logic [7:0] a5_seq;
    a5_seq = 8'b1010_0101;  // bit k = k-th expected sipo_data: 1,0,1,0,0,1,0,1

    reset = 1'b1; rx_in = 1'b1; rx_ready = 1'b0;
    tick(3);
    chk("reset_outs", all_outs(), 8'h00);
    reset = 1'b0;
    tick(4);
    chk("idle_outs", all_outs(), 8'h00);

    // Frame 0xA5, consumer not ready
    build_frame(8'hA5, 1'b1);
    run_cycles(FRAME + 20);
    chk("a5_nshift", shift_cyc.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < shift_cyc.size()) begin
        chk($sformatf("a5_shift_cyc%0d", k), shift_cyc[k], T0 + CPB / 2 + (k + 1) * CPB);
        chk($sformatf("a5_shift_bit%0d", k), shift_bit[k], a5_seq[k]);
      end
    end
    chk("a5_busy_before_t0", busy_hist[T0 - 1], 1'b0);
    chk("a5_busy_at_t0", busy_hist[T0], 1'b1);
    chk("a5_enable_rise", en_rise, T0 + CPB / 2);
    chk("a5_enable_drop", en_drop, STOP_DEC);
    chk("a5_valid_before_stop", valid_hist[STOP_DEC - 1], 1'b0);
    chk("a5_valid_after_stop", valid_hist[STOP_DEC + 1], 1'b1);
    chk("a5_ferr", ferr_cnt, 0);
    chk("a5_ovr", ovr_cnt, 0);
    chk("a5_perr", perr_cnt, 0);
    tick(10);
    chk("a5_valid_held", rx_valid, 1'b1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    chk("a5_valid_cleared", rx_valid, 1'b0);

    // 4-cycle low glitch
    push_bits(1'b0, 4);
    run_cycles(30);
    chk("glitch_nshift", shift_cyc.size(), 0);
    chk("glitch_busy_start", busy_hist[T0], 1'b1);
    chk("glitch_busy_abort", busy_hist[T0 + CPB / 2], 1'b0);
    chk("glitch_busy_end", rx_busy, 1'b0);
    chk("glitch_enable", en_rise, -1);

    // 0x3C with low stop bit, line held low 40 more cycles
    build_frame(8'h3C, 1'b0);
    push_bits(1'b0, 40);
    run_cycles(FRAME + 40 + 30);
    chk("brk_nshift", shift_cyc.size(), 8);
    chk("brk_byte", byte_at(0), 8'h3C);
    chk("brk_ferr_cnt", ferr_cnt, 1);
    chk("brk_ferr_cyc", ferr_cyc, STOP_DEC);
    chk("brk_enable_drop", en_drop, STOP_DEC);
    chk("brk_valid_none", valid_count(), 0);
    chk("brk_busy_held", busy_hist[FRAME + 40], 1'b1);
    chk("brk_busy_exit", busy_hist[FRAME + 43], 1'b0);
    chk("brk_busy_end", rx_busy, 1'b0);

    // Back-to-back 0x11 then 0x22, consumer not ready
    build_frame(8'h11, 1'b1);
    build_frame(8'h22, 1'b1);
    run_cycles(2 * FRAME + 20);
    chk("b2b_nshift", shift_cyc.size(), 16);
    chk("b2b_byte0", byte_at(0), 8'h11);
    chk("b2b_byte1", byte_at(8), 8'h22);
    chk("b2b_valid_first", valid_hist[STOP_DEC + 1], 1'b1);
    chk("b2b_ovr_cnt", ovr_cnt, 1);
    chk("b2b_ovr_cyc", ovr_cyc, FRAME + STOP_DEC);
    chk("b2b_valid_second", valid_hist[FRAME + STOP_DEC + 1], 1'b1);
    chk("b2b_ferr", ferr_cnt, 0);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    chk("b2b_valid_cleared", rx_valid, 1'b0);

    // Reset after data bit 3 of 0xFF, then a clean 0x55
    build_frame(8'hFF, 1'b1);
    run_cycles(T0 + CPB / 2 + 4 * CPB + 2);
    chk("rst_nshift", shift_cyc.size(), 4);
    chk("rst_pre_busy", rx_busy, 1'b1);
    rx_in = 1'b1;
    reset = 1'b1;
    #1;
    chk("rst_async_outs", all_outs(), 8'h00);
    tick(2);
    reset = 1'b0;
    run_cycles(40);
    chk("rst_no_valid", valid_count(), 0);
    chk("rst_no_busy", busy_count(), 0);
    chk("rst_no_ferr", ferr_cnt, 0);
    build_frame(8'h55, 1'b1);
    run_cycles(FRAME + 20);
    chk("rst_55_nshift", shift_cyc.size(), 8);
    chk("rst_55_byte", byte_at(0), 8'h55);
    chk("rst_55_valid", valid_hist[STOP_DEC + 1], 1'b1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;

`ifdef UART_RX_PARITY_EN
    // 0x07 with parity bit 0 under even parity
    push_bits(1'b0, CPB);
    for (int k = 0; k < 8; k++) push_bits(((k < 3) ? 1'b1 : 1'b0), CPB);
    push_bits(1'b0, CPB);
    push_bits(1'b1, CPB);
    run_cycles(FRAME + 20);
    chk("par_byte", byte_at(0), 8'h07);
    chk("par_err_cnt", perr_cnt, 1);
    chk("par_err_cyc", perr_cyc, T0 + CPB / 2 + 9 * CPB);
    chk("par_valid", valid_hist[STOP_DEC + 1], 1'b1);
    chk("par_ferr", ferr_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
